q_env_step: RTL and testbench

- Upstream driver for the q_learning update engine: a grid-world environment plus epsilon-greedy policy that generates (st, at, next_st, rt) update tuples.
- Each tuple is handed to q_learning with a one-cycle valid pulse.
- The block then waits for q_learning's o_valid and uses the returned o_at_max as the greedy action for the next step.
- It runs episodes from START_STATE to GOAL_STATE until NUM_EPISODES are done or it is stopped.

---
 rtl/q_env_step_pkg.sv | 33 +++
 rtl/q_env_lfsr.sv | 27 ++
 rtl/q_env_step.sv | 162 ++++++++++++++++
 tb/tb_q_env_step.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_env_step_pkg.sv
// Shared widths, grid defaults, action encodings, reward constants and FSM
// states for the grid-world environment that feeds the q_learning engine.
package q_env_step_pkg;

  localparam int STATES_WIDTH  = 4;
  localparam int ACTIONS_WIDTH = 2;
  localparam int DATA_WIDTH    = 32;

  localparam int DEF_GRID_W = 4;
  localparam int DEF_GRID_H = 4;

  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  localparam logic [ACTIONS_WIDTH-1:0] ACT_UP    = 2'd0;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_DOWN  = 2'd1;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_LEFT  = 2'd2;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_RIGHT = 2'd3;

  // IEEE-754 single precision: +100.0, -10.0, -1.0
  localparam logic [DATA_WIDTH-1:0] DEF_REWARD_GOAL = 32'h42C80000;
  localparam logic [DATA_WIDTH-1:0] DEF_REWARD_WALL = 32'hC1200000;
  localparam logic [DATA_WIDTH-1:0] DEF_REWARD_STEP = 32'hBF800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_ADVANCE,
    ST_DONE
  } env_state_t;

endpackage

// File: rtl/q_env_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that only steps when enabled.
// Only the low ten bits leave the block: [7:0] is the exploration draw and
// [9:8] the random action.
module q_env_lfsr
  import q_env_step_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] rnd
);

  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rnd      = lfsr[9:0];

  // Shift left, inserting the feedback bit, once per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else if (en) lfsr <= {lfsr[14:0], feedback};
  end

endmodule

// File: rtl/q_env_step.sv
// Grid-world environment with an epsilon-greedy policy. Each step picks an
// action, computes the move and reward, hands the tuple to q_learning with a
// one-cycle valid pulse, then waits for the engine's greedy action.
module q_env_step
  import q_env_step_pkg::*;
#(
  parameter int                    GRID_W       = DEF_GRID_W,
  parameter int                    GRID_H       = DEF_GRID_H,
  parameter int                    START_STATE  = 0,
  parameter int                    GOAL_STATE   = 15,
  parameter int                    MAX_STEPS    = 64,
  parameter int                    NUM_EPISODES = 16,
  parameter logic [7:0]            EPSILON      = 8'd26,
  parameter logic [15:0]           LFSR_SEED    = DEF_LFSR_SEED,
  parameter logic [DATA_WIDTH-1:0] REWARD_GOAL  = DEF_REWARD_GOAL,
  parameter logic [DATA_WIDTH-1:0] REWARD_WALL  = DEF_REWARD_WALL,
  parameter logic [DATA_WIDTH-1:0] REWARD_STEP  = DEF_REWARD_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic                     o_valid,
  output logic [STATES_WIDTH-1:0]  o_st,
  output logic [STATES_WIDTH-1:0]  o_next_st,
  output logic [ACTIONS_WIDTH-1:0] o_at,
  output logic [DATA_WIDTH-1:0]    o_rt,
  input  logic                     i_valid,
  input  logic [ACTIONS_WIDTH-1:0] i_at_max,
  output logic                     o_busy,
  output logic [15:0]              o_episode,
  output logic                     o_finished
);

  localparam int COL_W = $clog2(GRID_W);
  localparam logic [STATES_WIDTH-1:0] START_ST = STATES_WIDTH'(START_STATE);
  localparam logic [STATES_WIDTH-1:0] GOAL_ST  = STATES_WIDTH'(GOAL_STATE);
  localparam logic [STATES_WIDTH-1:0] COL_MASK = STATES_WIDTH'(GRID_W - 1);
  localparam logic [STATES_WIDTH-1:0] LAST_ROW = STATES_WIDTH'(GRID_H - 1);
  localparam logic [STATES_WIDTH-1:0] ROW_STEP = STATES_WIDTH'(GRID_W);
  localparam logic [15:0] LAST_STEP    = 16'(MAX_STEPS - 1);
  localparam logic [15:0] LAST_EPISODE = 16'(NUM_EPISODES - 1);

  env_state_t state, state_next;

  logic [STATES_WIDTH-1:0]  st;
  logic [ACTIONS_WIDTH-1:0] greedy;
  logic [15:0]              step_cnt;
  logic                     stop_flag;

  logic [9:0]               rnd;
  logic [ACTIONS_WIDTH-1:0] act;
  logic [STATES_WIDTH-1:0]  row, col, move_next;
  logic [DATA_WIDTH-1:0]    move_rt;
  logic                     hit_wall;
  logic                     episode_end;

  q_env_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_SELECT),
    .rnd (rnd)
  );

  assign o_valid     = (state == ST_ISSUE);
  assign o_finished  = (state == ST_DONE);
  assign o_busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign episode_end = (o_next_st == GOAL_ST) || (step_cnt == LAST_STEP);

  // Epsilon-greedy action choice, then the grid move and its reward.
  always_comb begin
    row       = st >> COL_W;
    col       = st & COL_MASK;
    act       = (rnd[7:0] < EPSILON) ? rnd[9:8] : greedy;
    hit_wall  = 1'b0;
    move_next = st;
    move_rt   = REWARD_STEP;
    case (act)
      ACT_UP:    if (row == '0)       hit_wall = 1'b1; else move_next = st - ROW_STEP;
      ACT_DOWN:  if (row == LAST_ROW) hit_wall = 1'b1; else move_next = st + ROW_STEP;
      ACT_LEFT:  if (col == '0)       hit_wall = 1'b1; else move_next = st - 1'b1;
      ACT_RIGHT: if (col == COL_MASK) hit_wall = 1'b1; else move_next = st + 1'b1;
      default:   hit_wall = 1'b0;
    endcase
    if (hit_wall) begin
      move_next = st;
      move_rt   = REWARD_WALL;
    end else if (move_next == GOAL_ST) begin
      move_rt = REWARD_GOAL;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: one step is SELECT, ISSUE, WAIT..., ADVANCE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (i_start) state_next = ST_SELECT;
      ST_SELECT:  state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (i_valid) state_next = ST_ADVANCE;
      ST_ADVANCE: begin
        if (episode_end && (o_episode == LAST_EPISODE)) state_next = ST_DONE;
        else if (stop_flag)                             state_next = ST_IDLE;
        else                                            state_next = ST_SELECT;
      end
      ST_DONE:    if (i_start) state_next = ST_SELECT;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Tuple registers, greedy capture, step/episode bookkeeping and stop latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= START_ST;
      greedy    <= '0;
      step_cnt  <= '0;
      stop_flag <= 1'b0;
      o_episode <= '0;
      o_st      <= '0;
      o_next_st <= '0;
      o_at      <= '0;
      o_rt      <= '0;
    end else begin
      if ((state != ST_IDLE) && i_stop) stop_flag <= 1'b1;
      case (state)
        ST_IDLE: if (i_start) o_episode <= '0;
        ST_SELECT: begin
          o_st      <= st;
          o_at      <= act;
          o_next_st <= move_next;
          o_rt      <= move_rt;
        end
        ST_WAIT: if (i_valid) greedy <= i_at_max;
        ST_ADVANCE: begin
          if (episode_end) begin
            st        <= START_ST;
            step_cnt  <= '0;
            greedy    <= '0;
            o_episode <= o_episode + 16'd1;
          end else begin
            st       <= o_next_st;
            step_cnt <= step_cnt + 16'd1;
          end
          if (state_next == ST_IDLE) stop_flag <= 1'b0;
        end
        ST_DONE: if (i_start) begin
          o_episode <= '0;
          step_cnt  <= '0;
          stop_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_env_step.sv
// Bench for q_env_step: directed sequences on a purely greedy instance and a
// randomized run of an exploring instance against a grid-world reference.
module tb_q_env_step;

  localparam logic [31:0] R_GOAL = 32'h42C80000;
  localparam logic [31:0] R_WALL = 32'hC1200000;
  localparam logic [31:0] R_STEP = 32'hBF800000;
  localparam int G_MAX_STEPS  = 8;
  localparam int G_EPISODES   = 2;
  localparam int R_EPISODES   = 4;
  localparam int R_MAX_STEPS  = 64;
  localparam int R_EPSILON    = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // greedy (EPSILON=0) instance
  logic g_start = 0, g_stop = 0, g_ivalid = 0;
  logic [1:0] g_atmax = 0;
  logic g_vout, g_busy, g_fin;
  logic [3:0] g_st, g_nx;
  logic [1:0] g_at;
  logic [31:0] g_rt;
  logic [15:0] g_ep;

  // exploring instance
  logic r_start = 0, r_stop = 0, r_ivalid = 0;
  logic [1:0] r_atmax = 0;
  logic r_vout, r_busy, r_fin;
  logic [3:0] r_st, r_nx;
  logic [1:0] r_at;
  logic [31:0] r_rt;
  logic [15:0] r_ep;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [3:0]  st;
    logic [1:0]  at;
    logic [3:0]  nx;
    logic [31:0] rt;
  } vec_t;
  vec_t path[7];

  q_env_step #(.EPSILON(8'd0), .MAX_STEPS(G_MAX_STEPS), .NUM_EPISODES(G_EPISODES)) dut_g (
    .clk(clk), .rst(rst), .i_start(g_start), .i_stop(g_stop), .o_valid(g_vout),
    .o_st(g_st), .o_next_st(g_nx), .o_at(g_at), .o_rt(g_rt), .i_valid(g_ivalid),
    .i_at_max(g_atmax), .o_busy(g_busy), .o_episode(g_ep), .o_finished(g_fin)
  );

  q_env_step #(.NUM_EPISODES(R_EPISODES)) dut_r (
    .clk(clk), .rst(rst), .i_start(r_start), .i_stop(r_stop), .o_valid(r_vout),
    .o_st(r_st), .o_next_st(r_nx), .o_at(r_at), .o_rt(r_rt), .i_valid(r_ivalid),
    .i_at_max(r_atmax), .o_busy(r_busy), .o_episode(r_ep), .o_finished(r_fin)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    g_start = 0; g_stop = 0; g_ivalid = 0; g_atmax = 0;
    r_start = 0; r_stop = 0; r_ivalid = 0; r_atmax = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseStartG();
    g_start = 1'b1;
    @(negedge clk);
    g_start = 1'b0;
  endtask

  task automatic waitIssueG(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (g_vout) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("g issue timeout", 64'(ok), 64'd1);
  endtask

  task automatic waitIssueR(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (r_vout) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("r issue timeout", 64'(ok), 64'd1);
  endtask

  // Respond to the greedy instance's update after 'delay' cycles.
  task automatic applyStimulus(input int delay, input logic [1:0] val);
    repeat (delay) @(negedge clk);
    g_ivalid = 1'b1;
    g_atmax  = val;
    @(negedge clk);
    g_ivalid = 1'b0;
  endtask

  task automatic checkTupleG(input string tag, input logic [3:0] st, input logic [1:0] at,
                             input logic [3:0] nx, input logic [31:0] rt);
    checkOutput({tag, " st"}, 64'(g_st), 64'(st));
    checkOutput({tag, " at"}, 64'(g_at), 64'(at));
    checkOutput({tag, " next_st"}, 64'(g_nx), 64'(nx));
    checkOutput({tag, " rt"}, 64'(g_rt), 64'(rt));
  endtask

  task automatic waitFinishedG();
    for (int i = 0; i < 20 && !g_fin; i++) @(negedge clk);
  endtask

  function automatic int lfsrNext(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 16'hFFFF;
  endfunction

  // Reference grid move on a 4x4 board using row/column arithmetic.
  task automatic modelMove(input int st, input int a, output int nx, output logic [31:0] rt);
    int r, c;
    r = st / 4;
    c = st % 4;
    case (a)
      0: r = r - 1;
      1: r = r + 1;
      2: c = c - 1;
      default: c = c + 1;
    endcase
    if (r < 0 || r > 3 || c < 0 || c > 3) begin
      nx = st;
      rt = R_WALL;
    end else begin
      nx = r * 4 + c;
      rt = (nx == 15) ? R_GOAL : R_STEP;
    end
  endtask

  initial begin
    bit ok;
    int vcount;
    logic [3:0] s_st, s_nx;
    logic [1:0] s_at;
    logic [31:0] s_rt;
    int m_st, m_greedy, m_lfsr, m_step, m_ep, a, nx, rsp, dly;
    logic [31:0] m_rt;

    path[0] = '{2'd3, 4'd0,  2'd0, 4'd0,  R_WALL};
    path[1] = '{2'd3, 4'd0,  2'd3, 4'd1,  R_STEP};
    path[2] = '{2'd3, 4'd1,  2'd3, 4'd2,  R_STEP};
    path[3] = '{2'd1, 4'd2,  2'd3, 4'd3,  R_STEP};
    path[4] = '{2'd1, 4'd3,  2'd1, 4'd7,  R_STEP};
    path[5] = '{2'd1, 4'd7,  2'd1, 4'd11, R_STEP};
    path[6] = '{2'd1, 4'd11, 2'd1, 4'd15, R_GOAL};

    // reset state
    doReset();
    checkOutput("reset outputs", {g_vout, g_st, g_nx, g_at, g_busy, g_fin},
                {1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0});
    checkOutput("reset rt", 64'(g_rt), 64'd0);
    checkOutput("reset episode", 64'(g_ep), 64'd0);

    // wall bump, greedy path to goal, two episodes to completion
    $display("[TB] greedy path / run completion");
    pulseStartG();
    for (int ep = 0; ep < G_EPISODES; ep++) begin
      for (int i = 0; i < 7; i++) begin
        waitIssueG(ok);
        if (!ok) break;
        checkTupleG($sformatf("path e%0d s%0d", ep, i), path[i].st, path[i].at, path[i].nx, path[i].rt);
        checkOutput("path episode", 64'(g_ep), 64'(ep));
        applyStimulus(1, path[i].resp);
      end
    end
    waitFinishedG();
    checkOutput("done finished", 64'(g_fin), 64'd1);
    checkOutput("done busy", 64'(g_busy), 64'd0);
    checkOutput("done episode", 64'(g_ep), 64'(G_EPISODES));
    g_ivalid = 1'b1;
    @(negedge clk);
    g_ivalid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g_vout) vcount++;
    end
    checkOutput("done stray i_valid", 64'(vcount), 64'd0);
    checkOutput("done still finished", 64'(g_fin), 64'd1);

    // step limit: always bump the top wall
    $display("[TB] step limit");
    doReset();
    pulseStartG();
    for (int i = 0; i < 2 * G_MAX_STEPS; i++) begin
      waitIssueG(ok);
      if (!ok) break;
      checkTupleG("limit", 4'd0, 2'd0, 4'd0, R_WALL);
      checkOutput("limit episode", 64'(g_ep), 64'(i / G_MAX_STEPS));
      applyStimulus(1, 2'd0);
    end
    waitFinishedG();
    checkOutput("limit finished", 64'(g_fin), 64'd1);
    checkOutput("limit episode end", 64'(g_ep), 64'(G_EPISODES));

    // stop during a slow handshake
    $display("[TB] stop with slow response");
    doReset();
    pulseStartG();
    waitIssueG(ok);
    s_st = g_st; s_at = g_at; s_nx = g_nx; s_rt = g_rt;
    checkTupleG("stop first", 4'd0, 2'd0, 4'd0, R_WALL);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g_stop  = (k == 2);
      g_start = (k == 5);
      checkOutput("hold valid/busy", {g_vout, g_busy}, 64'b01);
      checkOutput("hold tuple", {g_st, g_at, g_nx, g_rt}, {s_st, s_at, s_nx, s_rt});
    end
    g_stop = 1'b0;
    g_start = 1'b0;
    applyStimulus(0, 2'd3);
    vcount = 0;
    for (int i = 0; i < 10 && g_busy; i++) begin
      @(negedge clk);
      if (g_vout) vcount++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (g_vout) vcount++;
    end
    checkOutput("stop busy", 64'(g_busy), 64'd0);
    checkOutput("stop finished", 64'(g_fin), 64'd0);
    checkOutput("stop no reissue", 64'(vcount), 64'd0);
    pulseStartG();
    waitIssueG(ok);
    checkTupleG("stop resume", 4'd0, 2'd3, 4'd1, R_STEP);
    applyStimulus(1, 2'd3);

    // reset while waiting for the engine
    $display("[TB] reset mid-wait");
    doReset();
    pulseStartG();
    for (int i = 0; i < 2; i++) begin
      waitIssueG(ok);
      applyStimulus(1, path[i].resp);
    end
    waitIssueG(ok);
    checkTupleG("pre-reset", 4'd1, 2'd3, 4'd2, R_STEP);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", {g_vout, g_st, g_nx, g_at, g_busy, g_fin, g_ep},
                {1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0});
    checkOutput("async reset rt", 64'(g_rt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 2'd2);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (g_vout || g_busy) vcount++;
    end
    checkOutput("late i_valid ignored", 64'(vcount), 64'd0);
    pulseStartG();
    waitIssueG(ok);
    checkTupleG("after reset", 4'd0, 2'd0, 4'd0, R_WALL);
    applyStimulus(1, 2'd0);

    // randomized run against the reference model
    $display("[TB] randomized run");
    doReset();
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    m_st = 0; m_greedy = 0; m_lfsr = 16'hACE1; m_step = 0; m_ep = 0;
    while (m_ep < R_EPISODES && n_fail < 30) begin
      waitIssueR(ok);
      if (!ok) break;
      a = ((m_lfsr & 255) < R_EPSILON) ? ((m_lfsr >> 8) & 3) : m_greedy;
      m_lfsr = lfsrNext(m_lfsr);
      modelMove(m_st, a, nx, m_rt);
      checkOutput("rand st", 64'(r_st), 64'(m_st));
      checkOutput("rand at", 64'(r_at), 64'(a));
      checkOutput("rand next_st", 64'(r_nx), 64'(nx));
      checkOutput("rand rt", 64'(r_rt), 64'(m_rt));
      checkOutput("rand episode", 64'(r_ep), 64'(m_ep));
      rsp = $urandom_range(0, 3);
      dly = $urandom_range(1, 4);
      repeat (dly) @(negedge clk);
      r_ivalid = 1'b1;
      r_atmax  = 2'(rsp);
      @(negedge clk);
      r_ivalid = 1'b0;
      m_greedy = rsp;
      m_step++;
      m_st = nx;
      if (nx == 15 || m_step == R_MAX_STEPS) begin
        m_st = 0; m_step = 0; m_greedy = 0; m_ep++;
      end
    end
    for (int i = 0; i < 20 && !r_fin; i++) @(negedge clk);
    checkOutput("rand finished", 64'(r_fin), 64'd1);
    checkOutput("rand episode end", 64'(r_ep), 64'(R_EPISODES));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
